waypoint_sequencer: RTL and testbench

//  Upstream stage of the position controller. Stores a list of waypoints (X, Y, THETA) and drives them as

---
 rtl/waypoint_sequencer_pkg.sv | 13 +
 rtl/waypoint_sequencer_ram.sv | 29 ++
 rtl/waypoint_sequencer.sv | 162 ++++++++++++++++
 tb/tb_waypoint_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/waypoint_sequencer_pkg.sv
// Shared constants for the waypoint sequencer: default coordinate format and FSM state encodings.
package waypoint_sequencer_pkg;

  localparam int N_WIDTH_DEF = 17;
  localparam int Q_WIDTH_DEF = 8;

  localparam logic [2:0] WPS_IDLE   = 3'd0;
  localparam logic [2:0] WPS_FETCH  = 3'd1;
  localparam logic [2:0] WPS_TRACK  = 3'd2;
  localparam logic [2:0] WPS_SETTLE = 3'd3;
  localparam logic [2:0] WPS_DONE   = 3'd4;

endpackage

// File: rtl/waypoint_sequencer_ram.sv
// Waypoint table: one write port, one registered read port. A write to the address being
// read in the same clock is forwarded, so a START issued alongside a write fetches the new entry.
module waypoint_sequencer_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 51
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (we && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/waypoint_sequencer.sv
// Waypoint sequencer: drives stored (X, Y, THETA) targets and advances after the goal flag settles.
// Optional macro WAYPOINT_SEQ_LOOP_EN: wrap to waypoint 0 after the last one instead of finishing.
module waypoint_sequencer
  import waypoint_sequencer_pkg::*;
#(
  parameter int N_WIDTH       = N_WIDTH_DEF,
  parameter int Q_WIDTH       = Q_WIDTH_DEF,
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic                WAYPOINT_SEQ_CLOCK_50,
  input  logic                WAYPOINT_SEQ_RESET_InLow,
  input  logic                WAYPOINT_SEQ_START_InHigh,
  input  logic                WAYPOINT_SEQ_ABORT_InHigh,
  input  logic                WAYPOINT_SEQ_WR_EN_InHigh,
  input  logic [ADDR_W-1:0]   WAYPOINT_SEQ_WR_ADDR_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQ_WR_X_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQ_WR_Y_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQ_WR_THETA_InBus,
  input  logic [ADDR_W:0]     WAYPOINT_SEQ_NUM_WP_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQ_CURRENTX_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQ_CURRENTY_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQ_CURRENTTHETA_InBus,
  input  logic                WAYPOINT_SEQ_GOAL_InLow,
  output logic [N_WIDTH-1:0]  WAYPOINT_SEQ_TARGETX_OutBus,
  output logic [N_WIDTH-1:0]  WAYPOINT_SEQ_TARGETY_OutBus,
  output logic [N_WIDTH-1:0]  WAYPOINT_SEQ_TARGETTHETA_OutBus,
  output logic [ADDR_W-1:0]   WAYPOINT_SEQ_INDEX_OutBus,
  output logic                WAYPOINT_SEQ_BUSY_OutHigh,
  output logic                WAYPOINT_SEQ_DONE_OutHigh
);

  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int WORD_W = 3 * N_WIDTH;

  // The fraction field must sit below the sign bit; nothing else here depends on Q_WIDTH.
  if (Q_WIDTH > N_WIDTH - 1) begin : g_bad_q_width
  end

  logic [2:0]         state_reg, state_next;
  logic [ADDR_W-1:0]  idx_reg, idx_next;
  logic [ADDR_W:0]    count_reg, count_next;
  logic [CNT_W-1:0]   settle_reg, settle_next;
  logic [N_WIDTH-1:0] tgt_x_reg, tgt_y_reg, tgt_th_reg;

  logic               idle_or_done;
  logic               wr_ok;
  logic               start_ok;
  logic [ADDR_W:0]    count_in;
  logic [ADDR_W:0]    idx_inc;
  logic [WORD_W-1:0]  rd_data;

  assign idle_or_done = (state_reg == WPS_IDLE) || (state_reg == WPS_DONE);
  assign wr_ok        = WAYPOINT_SEQ_WR_EN_InHigh && idle_or_done;
  assign start_ok     = WAYPOINT_SEQ_START_InHigh && idle_or_done && (WAYPOINT_SEQ_NUM_WP_InBus != '0);
  assign count_in     = (WAYPOINT_SEQ_NUM_WP_InBus > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH)
                                                                        : WAYPOINT_SEQ_NUM_WP_InBus;
  assign idx_inc      = {1'b0, idx_reg} + (ADDR_W+1)'(1);

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    count_next  = count_reg;
    settle_next = settle_reg;
    if (WAYPOINT_SEQ_ABORT_InHigh) begin
      state_next  = WPS_IDLE;
      settle_next = '0;
    end else begin
      case (state_reg)
        WPS_IDLE, WPS_DONE: begin
          if (start_ok) begin
            state_next  = WPS_FETCH;
            idx_next    = '0;
            count_next  = count_in;
            settle_next = '0;
          end
        end
        WPS_FETCH: state_next = WPS_TRACK;
        WPS_TRACK: begin
          if (!WAYPOINT_SEQ_GOAL_InLow) begin
            state_next  = WPS_SETTLE;
            settle_next = CNT_W'(1);
          end
        end
        WPS_SETTLE: begin
          if (WAYPOINT_SEQ_GOAL_InLow) begin
            state_next  = WPS_TRACK;
            settle_next = '0;
          end else if (settle_reg == CNT_W'(SETTLE_CYCLES)) begin
            settle_next = '0;
            if (idx_inc < count_reg) begin
              idx_next   = idx_reg + ADDR_W'(1);
              state_next = WPS_FETCH;
            end else begin
`ifdef WAYPOINT_SEQ_LOOP_EN
              idx_next   = '0;
              state_next = WPS_FETCH;
`else
              state_next = WPS_DONE;
`endif
            end
          end else begin
            settle_next = settle_reg + CNT_W'(1);
          end
        end
        default: state_next = WPS_IDLE;
      endcase
    end
  end

  // Reading at idx_next lands the entry in rd_data by the time the FSM sits in FETCH.
  waypoint_sequencer_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (WORD_W)
  ) u_ram (
    .clk     (WAYPOINT_SEQ_CLOCK_50),
    .we      (wr_ok),
    .wr_addr (WAYPOINT_SEQ_WR_ADDR_InBus),
    .wr_data ({WAYPOINT_SEQ_WR_X_InBus, WAYPOINT_SEQ_WR_Y_InBus, WAYPOINT_SEQ_WR_THETA_InBus}),
    .rd_addr (idx_next),
    .rd_data (rd_data)
  );

  always_ff @(posedge WAYPOINT_SEQ_CLOCK_50 or negedge WAYPOINT_SEQ_RESET_InLow) begin
    if (!WAYPOINT_SEQ_RESET_InLow) begin
      state_reg  <= WPS_IDLE;
      idx_reg    <= '0;
      count_reg  <= '0;
      settle_reg <= '0;
      tgt_x_reg  <= '0;
      tgt_y_reg  <= '0;
      tgt_th_reg <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      count_reg  <= count_next;
      settle_reg <= settle_next;
      if (state_reg == WPS_IDLE) begin
        tgt_x_reg  <= WAYPOINT_SEQ_CURRENTX_InBus;
        tgt_y_reg  <= WAYPOINT_SEQ_CURRENTY_InBus;
        tgt_th_reg <= WAYPOINT_SEQ_CURRENTTHETA_InBus;
      end else if (state_reg == WPS_FETCH) begin
        {tgt_x_reg, tgt_y_reg, tgt_th_reg} <= rd_data;
      end
    end
  end

  assign WAYPOINT_SEQ_TARGETX_OutBus     = tgt_x_reg;
  assign WAYPOINT_SEQ_TARGETY_OutBus     = tgt_y_reg;
  assign WAYPOINT_SEQ_TARGETTHETA_OutBus = tgt_th_reg;
  assign WAYPOINT_SEQ_INDEX_OutBus       = idx_reg;
  assign WAYPOINT_SEQ_BUSY_OutHigh       = (state_reg == WPS_FETCH) || (state_reg == WPS_TRACK) ||
                                           (state_reg == WPS_SETTLE);
`ifdef WAYPOINT_SEQ_LOOP_EN
  assign WAYPOINT_SEQ_DONE_OutHigh       = 1'b0;
`else
  assign WAYPOINT_SEQ_DONE_OutHigh       = (state_reg == WPS_DONE);
`endif

endmodule

// File: tb/tb_waypoint_sequencer.sv
// Directed bench for waypoint_sequencer (DEPTH=4, SETTLE_CYCLES=4); honours WAYPOINT_SEQ_LOOP_EN.
module tb_waypoint_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, wr_en, goal;
  logic [1:0]  wr_addr;
  logic [16:0] wr_x, wr_y, wr_th;
  logic [2:0]  num_wp;
  logic [16:0] cur_x, cur_y, cur_th;
  logic [16:0] tgt_x, tgt_y, tgt_th;
  logic [1:0]  index;
  logic        busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  waypoint_sequencer #(
    .N_WIDTH(17), .Q_WIDTH(8), .DEPTH(4), .ADDR_W(2), .SETTLE_CYCLES(4)
  ) dut (
    .WAYPOINT_SEQ_CLOCK_50           (clk),
    .WAYPOINT_SEQ_RESET_InLow        (rst_n),
    .WAYPOINT_SEQ_START_InHigh       (start),
    .WAYPOINT_SEQ_ABORT_InHigh       (abort),
    .WAYPOINT_SEQ_WR_EN_InHigh       (wr_en),
    .WAYPOINT_SEQ_WR_ADDR_InBus      (wr_addr),
    .WAYPOINT_SEQ_WR_X_InBus         (wr_x),
    .WAYPOINT_SEQ_WR_Y_InBus         (wr_y),
    .WAYPOINT_SEQ_WR_THETA_InBus     (wr_th),
    .WAYPOINT_SEQ_NUM_WP_InBus       (num_wp),
    .WAYPOINT_SEQ_CURRENTX_InBus     (cur_x),
    .WAYPOINT_SEQ_CURRENTY_InBus     (cur_y),
    .WAYPOINT_SEQ_CURRENTTHETA_InBus (cur_th),
    .WAYPOINT_SEQ_GOAL_InLow         (goal),
    .WAYPOINT_SEQ_TARGETX_OutBus     (tgt_x),
    .WAYPOINT_SEQ_TARGETY_OutBus     (tgt_y),
    .WAYPOINT_SEQ_TARGETTHETA_OutBus (tgt_th),
    .WAYPOINT_SEQ_INDEX_OutBus       (index),
    .WAYPOINT_SEQ_BUSY_OutHigh       (busy),
    .WAYPOINT_SEQ_DONE_OutHigh       (done)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_wp(input logic [1:0] a, input logic [16:0] x, input logic [16:0] y,
                          input logic [16:0] t);
    wr_en = 1'b1; wr_addr = a; wr_x = x; wr_y = y; wr_th = t;
    tick();
    wr_en = 1'b0;
    $display("[TB] write wp[%0d] = (%05h, %05h, %05h)", a, x, y, t);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; wr_en = 0; goal = 1; wr_addr = 0;
    wr_x = 0; wr_y = 0; wr_th = 0; num_wp = 0;
    cur_x = 17'h00500; cur_y = 17'h00020; cur_th = 17'h00003;
    tick(2);
    tests_run++; if (tgt_x !== 17'h0) begin tests_failed++; $display("FAIL reset_tgt_x got %05h exp 00000", tgt_x); end
    tests_run++; if (index !== 2'd0) begin tests_failed++; $display("FAIL reset_index got %0d exp 0", index); end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done); end
    rst_n = 1'b1;
    tick();
    tests_run++; if (tgt_x !== 17'h00500) begin tests_failed++; $display("FAIL reset_follow_x got %05h exp 00500", tgt_x); end
    tests_run++; if (tgt_y !== 17'h00020) begin tests_failed++; $display("FAIL reset_follow_y got %05h exp 00020", tgt_y); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_run();
    write_wp(2'd0, 17'h00100, 17'h00000, 17'h00000);
    write_wp(2'd1, 17'h00200, 17'h00100, 17'h00000);
    write_wp(2'd2, 17'h00000, 17'h00000, 17'h10000);
    num_wp = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL run_fetch_busy got %b exp 1", busy); end
    tick();
    tests_run++; if (tgt_x !== 17'h00100) begin tests_failed++; $display("FAIL run_wp0_x got %05h exp 00100", tgt_x); end
    goal = 1'b0;
    tick(5);
    tests_run++; if (index !== 2'd1 || tgt_x !== 17'h00100) begin tests_failed++; $display("FAIL run_fetch1 got idx=%0d x=%05h exp 1 00100", index, tgt_x); end
    tick();
    tests_run++; if (tgt_x !== 17'h00200 || tgt_y !== 17'h00100) begin tests_failed++; $display("FAIL run_wp1 got %05h,%05h exp 00200,00100", tgt_x, tgt_y); end
    tick(6);
    tests_run++; if (tgt_th !== 17'h10000 || tgt_x !== 17'h0 || index !== 2'd2) begin tests_failed++; $display("FAIL run_wp2 got th=%05h x=%05h idx=%0d exp 10000 00000 2", tgt_th, tgt_x, index); end
    tick(5);
`ifdef WAYPOINT_SEQ_LOOP_EN
    tests_run++; if (done !== 1'b0 || busy !== 1'b1 || index !== 2'd0) begin tests_failed++; $display("FAIL loop_wrap got done=%b busy=%b idx=%0d exp 0 1 0", done, busy, index); end
    tick();
    tests_run++; if (tgt_x !== 17'h00100) begin tests_failed++; $display("FAIL loop_wp0_x got %05h exp 00100", tgt_x); end
`else
    tests_run++; if (done !== 1'b1 || busy !== 1'b0 || index !== 2'd2) begin tests_failed++; $display("FAIL run_done got done=%b busy=%b idx=%0d exp 1 0 2", done, busy, index); end
    tests_run++; if (tgt_th !== 17'h10000) begin tests_failed++; $display("FAIL run_done_hold got %05h exp 10000", tgt_th); end
`endif
    goal = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    tests_run++; if (busy !== 1'b0 || tgt_x !== 17'h00500) begin tests_failed++; $display("FAIL run_abort_idle got busy=%b x=%05h exp 0 00500", busy, tgt_x); end
    $display("[TB] test_run done");
  endtask

  task automatic test_glitch();
    num_wp = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    goal = 1'b0;
    tick(3);
    goal = 1'b1;
    tick(3);
    tests_run++; if (index !== 2'd0 || busy !== 1'b1 || tgt_x !== 17'h00100) begin tests_failed++; $display("FAIL glitch got idx=%0d busy=%b x=%05h exp 0 1 00100", index, busy, tgt_x); end
    $display("[TB] test_glitch done");
  endtask

  task automatic test_abort();
    goal = 1'b0;
    tick(4);
    tests_run++; if (index !== 2'd0) begin tests_failed++; $display("FAIL abort_pre got idx=%0d exp 0", index); end
    abort = 1'b1;
    tick();
    abort = 1'b0; goal = 1'b1;
    tests_run++; if (busy !== 1'b0 || index !== 2'd0 || done !== 1'b0) begin tests_failed++; $display("FAIL abort_idle got busy=%b idx=%0d done=%b exp 0 0 0", busy, index, done); end
    cur_x = 17'h00777;
    tick();
    tests_run++; if (tgt_x !== 17'h00777) begin tests_failed++; $display("FAIL abort_follow got %05h exp 00777", tgt_x); end
    $display("[TB] test_abort done");
  endtask

  task automatic test_edges();
    num_wp = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_start got busy=%b exp 0", busy); end
    write_wp(2'd3, 17'h00300, 17'h00040, 17'h00080);
    num_wp = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 2'd0; wr_x = 17'h000AA; goal = 1'b0;
    tick();
    wr_en = 1'b0;
    tick(5);
    tests_run++; if (index !== 2'd1 || tgt_x !== 17'h00200) begin tests_failed++; $display("FAIL clamp_wp1 got idx=%0d x=%05h exp 1 00200", index, tgt_x); end
    tick(12);
    tests_run++; if (index !== 2'd3 || tgt_x !== 17'h00300 || tgt_y !== 17'h00040) begin tests_failed++; $display("FAIL clamp_wp3 got idx=%0d x=%05h y=%05h exp 3 00300 00040", index, tgt_x, tgt_y); end
    tick(5);
`ifdef WAYPOINT_SEQ_LOOP_EN
    tests_run++; if (index !== 2'd0 || busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL clamp_end got idx=%0d busy=%b done=%b exp 0 1 0", index, busy, done); end
`else
    tests_run++; if (index !== 2'd3 || done !== 1'b1) begin tests_failed++; $display("FAIL clamp_end got idx=%0d done=%b exp 3 1", index, done); end
`endif
    goal = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; num_wp = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests_run++; if (tgt_x !== 17'h00100) begin tests_failed++; $display("FAIL busy_write_dropped got %05h exp 00100", tgt_x); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd0; wr_x = 17'h00123; wr_y = 17'h00011; wr_th = 17'h00001;
    start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    tick();
    tests_run++; if (tgt_x !== 17'h00123 || tgt_y !== 17'h00011) begin tests_failed++; $display("FAIL wr_start_same got %05h,%05h exp 00123,00011", tgt_x, tgt_y); end
    $display("[TB] test_edges done");
  endtask

  initial begin
    test_reset();
    test_run();
    test_glitch();
    test_abort();
    test_edges();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
